// File: rtl/if_fetch_ctrl_if.sv
// Instruction-fetch controller port bundle: loader handshake, hazard/redirect inputs,
// instruction-memory port and the IF/ID outputs.
// master = the fetch controller, slave = its environment (loader, hazard unit, imem, IF/ID).
interface if_fetch_ctrl_if #(
  parameter int unsigned AW = 12
);
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_done;
  logic          load_ready;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic [AW-1:0] imem_addr;
  logic          imem_we;
  logic [31:0]   imem_wdata;
  logic [31:0]   imem_rdata;
  logic [31:0]   IR;
  logic [AW-1:0] NPC;
  logic          if_valid;
  logic [10:0]   load_count;

  modport master (
    input  load_valid, load_data, load_done, stall, branch_taken, branch_target, imem_rdata,
    output load_ready, imem_addr, imem_we, imem_wdata, IR, NPC, if_valid, load_count
  );

  modport slave (
    output load_valid, load_data, load_done, stall, branch_taken, branch_target, imem_rdata,
    input  load_ready, imem_addr, imem_we, imem_wdata, IR, NPC, if_valid, load_count
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: boot loader for the instruction memory, then PC/IR/NPC
// generation for IF/ID with stall, branch redirect and post-redirect bubbles.
module if_fetch_ctrl #(
  parameter int unsigned   AW             = 12,
  parameter int unsigned   IMEM_WORDS     = 1024,
  parameter logic [AW-1:0] BOOT_PC        = '0,
  parameter logic [31:0]   NOP_INSTR      = 32'h0,
  parameter int unsigned   BRANCH_BUBBLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_ctrl_if.master bus
);

  localparam int unsigned BW = (BRANCH_BUBBLES > 1) ? $clog2(BRANCH_BUBBLES) : 1;
  localparam logic [BW-1:0] BubbleInit = BW'(BRANCH_BUBBLES - 1);
  localparam logic          MultiBubble = (BRANCH_BUBBLES > 1);

  typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] load_ptr_q, load_ptr_d;
  logic [10:0]   load_count_q, load_count_d;
  logic [31:0]   ir_q, ir_d;
  logic [AW-1:0] npc_q, npc_d;
  logic          valid_q, valid_d;
  logic [BW-1:0] bubble_q, bubble_d;

  logic          load_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic          count_ok;
  logic [AW-1:0] redirect_pc;

  assign count_ok    = 32'(load_count_q) < IMEM_WORDS;
  // Redirect targets are forced word aligned.
  assign redirect_pc = {bus.branch_target[AW-1:2], 2'b00};

  // Next-state, loader handshake and memory-port steering.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    load_ptr_d   = load_ptr_q;
    load_count_d = load_count_q;
    ir_d         = ir_q;
    npc_d        = npc_q;
    valid_d      = valid_q;
    bubble_d     = bubble_q;
    load_ready   = 1'b0;
    imem_we      = 1'b0;
    imem_addr    = pc_q;

    unique case (state_q)
      StBoot: begin
        load_ready = count_ok;
        imem_addr  = load_ptr_q;
        imem_we    = bus.load_valid & count_ok;
        if (imem_we) begin
          load_ptr_d   = load_ptr_q + AW'(4);
          load_count_d = load_count_q + 11'd1;
        end
        if (bus.load_done) begin
          state_d = StRun;
        end
      end
      StRun, StFlush: begin
        if (bus.branch_taken) begin
          pc_d     = redirect_pc;
          ir_d     = NOP_INSTR;
          valid_d  = 1'b0;
          bubble_d = BubbleInit;
          state_d  = MultiBubble ? StFlush : StRun;
        end else if (state_q == StFlush) begin
          // Stall has no effect while bubbles drain.
          ir_d    = NOP_INSTR;
          valid_d = 1'b0;
          if (bubble_q <= BW'(1)) begin
            bubble_d = '0;
            state_d  = StRun;
          end else begin
            bubble_d = bubble_q - BW'(1);
          end
        end else if (!bus.stall) begin
          ir_d    = bus.imem_rdata;
          npc_d   = pc_q + AW'(4);
          valid_d = 1'b1;
          pc_d    = pc_q + AW'(4);
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // State registers with asynchronous reset; memory contents are untouched by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StBoot;
      pc_q         <= BOOT_PC;
      load_ptr_q   <= '0;
      load_count_q <= '0;
      ir_q         <= NOP_INSTR;
      npc_q        <= '0;
      valid_q      <= 1'b0;
      bubble_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      load_ptr_q   <= load_ptr_d;
      load_count_q <= load_count_d;
      ir_q         <= ir_d;
      npc_q        <= npc_d;
      valid_q      <= valid_d;
      bubble_q     <= bubble_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = imem_addr;
  assign bus.imem_wdata = bus.load_data;
  assign bus.IR         = ir_q;
  assign bus.NPC        = npc_q;
  assign bus.if_valid   = valid_q;
  assign bus.load_count = load_count_q;

endmodule
